// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU front-end: command kinds, sequencer
// states, ALU opcodes and the latched command record.
package alu_seq_pkg;

   // Command kinds (6 and 7 are illegal)
   localparam logic [2:0] K_BIN = 3'd0;
   localparam logic [2:0] K_UNI = 3'd1;
   localparam logic [2:0] K_LDA = 3'd2;
   localparam logic [2:0] K_LDF = 3'd3;
   localparam logic [2:0] K_SAV = 3'd4;
   localparam logic [2:0] K_RST = 3'd5;

   // ALU opcodes, one definition for decoder, sequencer and ALU
   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_ADC = 5'd1;
   localparam logic [4:0] OP_SUB = 5'd2;
   localparam logic [4:0] OP_SBB = 5'd3;
   localparam logic [4:0] OP_ANA = 5'd4;
   localparam logic [4:0] OP_XRA = 5'd5;
   localparam logic [4:0] OP_ORA = 5'd6;
   localparam logic [4:0] OP_CMP = 5'd7;
   localparam logic [4:0] OP_RLC = 5'd8;
   localparam logic [4:0] OP_RRC = 5'd9;
   localparam logic [4:0] OP_RAL = 5'd10;
   localparam logic [4:0] OP_RAR = 5'd11;
   localparam logic [4:0] OP_CMA = 5'd12;
   localparam logic [4:0] OP_STC = 5'd13;
   localparam logic [4:0] OP_CMC = 5'd14;
   localparam logic [4:0] OP_INR = 5'd15;
   localparam logic [4:0] OP_DCR = 5'd16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_EXEC   = 3'd2,
      S_SETTLE = 3'd3,
      S_RESP   = 3'd4
   } state_e;

   typedef struct packed {
      logic       id;
      logic [2:0] kind;
      logic [4:0] opcode;
      logic [7:0] operand;
   } cmd_t;

   function automatic logic kind_legal(input logic [2:0] k);
      return (k <= K_RST);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational; the owner keeps
// last_id. A sole requester always wins, a tie goes to the one that
// did not win last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_id,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       id
);

   // pick the winner and form the one-hot grant
   always_comb begin
      gnt = 2'b00;
      id  = 1'b0;
      if (en && (|req)) begin
         id  = (req == 2'b11) ? ~last_id : req[1];
         gnt = id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for the 8-bit accumulator ALU. Arbitrates between
// two requesters, steps the ALU strobes in order and returns the
// accumulator and flags with a one-cycle done pulse.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [3*N_REQ-1:0] req_kind,
   input  logic [5*N_REQ-1:0] req_opcode,
   input  logic [8*N_REQ-1:0] req_operand,
   output logic [N_REQ-1:0]   gnt,
   output logic               busy,
   output logic               done,
   output logic               done_id,
   output logic               err,
   output logic [7:0]         result,
   output logic [7:0]         flags,
   output logic               alu_ctrl_sig,
   output logic               alu_flags_write_en,
   output logic               alu_acc_write_en,
   output logic               alu_act_store,
   output logic               alu_act_restore,
   output logic               alu_tmp_write_en,
   output logic [4:0]         alu_opcode,
   output logic [7:0]         alu_data,
   input  logic [7:0]         alu_out,
   input  logic [7:0]         alu_flags
);

   state_e     state_q, state_d;
   cmd_t       cmd_q, cmd_d;
   logic       last_id_q, last_id_d;
   logic       err_q, err_d;
   logic [7:0] result_q, result_d;
   logic [7:0] flags_q, flags_d;

   logic [1:0] arb_gnt;
   logic       arb_id;
   logic [2:0] sel_kind;

   // grants are only offered while idle, never in RESP
   rr_arb2 u_arb (
      .req    (req),
      .last_id(last_id_q),
      .en     (state_q == S_IDLE),
      .gnt    (arb_gnt),
      .id     (arb_id)
   );

   assign gnt      = arb_gnt;
   assign sel_kind = req_kind[3*arb_id +: 3];

   // next state, command latch, round-robin pointer and response capture
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      last_id_d = last_id_q;
      err_d     = err_q;
      result_d  = result_q;
      flags_d   = flags_q;
      case (state_q)
         S_IDLE: begin
            if (|arb_gnt) begin
               cmd_d.id      = arb_id;
               cmd_d.kind    = sel_kind;
               cmd_d.opcode  = req_opcode[5*arb_id +: 5];
               cmd_d.operand = req_operand[8*arb_id +: 8];
               last_id_d     = arb_id;
               err_d         = !kind_legal(sel_kind);
               if (!kind_legal(sel_kind))  state_d = S_RESP;
               else if (sel_kind == K_BIN) state_d = S_SETUP;
               else                        state_d = S_EXEC;
            end
         end
         S_SETUP:  state_d = S_EXEC;
         S_EXEC:   state_d = S_SETTLE;
         S_SETTLE: begin
            // ALU updates from EXEC have landed by now
            state_d  = S_RESP;
            result_d = alu_out;
            flags_d  = alu_flags;
         end
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // state and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         last_id_q <= 1'b1;
         err_q     <= 1'b0;
         result_q  <= 8'h00;
         flags_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         last_id_q <= last_id_d;
         err_q     <= err_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
      end
   end

   // ALU strobes and operand presentation, decoded from the state register
   // so an asynchronous reset drops them immediately
   always_comb begin
      alu_ctrl_sig       = 1'b0;
      alu_flags_write_en = 1'b0;
      alu_acc_write_en   = 1'b0;
      alu_act_store      = 1'b0;
      alu_act_restore    = 1'b0;
      alu_tmp_write_en   = 1'b0;
      alu_opcode         = 5'd0;
      alu_data           = 8'h00;
      if (state_q == S_SETUP || state_q == S_EXEC || state_q == S_SETTLE) begin
         alu_opcode = cmd_q.opcode;
         alu_data   = cmd_q.operand;
      end
      if (state_q == S_SETUP) alu_tmp_write_en = 1'b1;
      if (state_q == S_EXEC) begin
         case (cmd_q.kind)
            K_BIN, K_UNI: alu_ctrl_sig       = 1'b1;
            K_LDA:        alu_acc_write_en   = 1'b1;
            K_LDF:        alu_flags_write_en = 1'b1;
            K_SAV:        alu_act_store      = 1'b1;
            K_RST:        alu_act_restore    = 1'b1;
            default:      ;
         endcase
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_RESP);
   assign done_id = done & cmd_q.id;
   assign err     = done & err_q;
   assign result  = result_q;
   assign flags   = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a stand-in ALU reacts to the strobes, and a
// command-level reference model predicts grants, per-cycle strobes and
// the returned accumulator/flags.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = '0;
   logic [5:0] req_kind = '0;
   logic [9:0] req_opcode = '0;
   logic [15:0] req_operand = '0;
   logic [1:0] gnt;
   logic       busy, done, done_id, err;
   logic [7:0] result, flags;
   logic       alu_ctrl_sig, alu_flags_write_en, alu_acc_write_en;
   logic       alu_act_store, alu_act_restore, alu_tmp_write_en;
   logic [4:0] alu_opcode;
   logic [7:0] alu_data, alu_out, alu_flags;

   always #5 clk = ~clk;

   alu_sequencer #(.N_REQ(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_kind(req_kind),
      .req_opcode(req_opcode), .req_operand(req_operand), .gnt(gnt),
      .busy(busy), .done(done), .done_id(done_id), .err(err),
      .result(result), .flags(flags), .alu_ctrl_sig(alu_ctrl_sig),
      .alu_flags_write_en(alu_flags_write_en), .alu_acc_write_en(alu_acc_write_en),
      .alu_act_store(alu_act_store), .alu_act_restore(alu_act_restore),
      .alu_tmp_write_en(alu_tmp_write_en), .alu_opcode(alu_opcode),
      .alu_data(alu_data), .alu_out(alu_out), .alu_flags(alu_flags)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      else n_pass++;
   endtask

   // ALU semantics: returns {flags, acc}; flags = {S, Z, 0000, C, 0}
   function automatic logic [15:0] alu_exec(input logic [4:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] fl);
      logic [8:0] w;
      logic [7:0] r, fr;
      logic c, c0;
      c0 = fl[1]; c = c0; r = a; w = '0;
      case (op)
         OP_ADD: begin w = {1'b0, a} + {1'b0, b};            r = w[7:0]; c = w[8]; end
         OP_ADC: begin w = {1'b0, a} + {1'b0, b} + {8'h0, c0}; r = w[7:0]; c = w[8]; end
         OP_SUB: begin w = {1'b0, a} - {1'b0, b};            r = w[7:0]; c = w[8]; end
         OP_SBB: begin w = {1'b0, a} - {1'b0, b} - {8'h0, c0}; r = w[7:0]; c = w[8]; end
         OP_ANA: begin r = a & b; c = 1'b0; end
         OP_XRA: begin r = a ^ b; c = 1'b0; end
         OP_ORA: begin r = a | b; c = 1'b0; end
         OP_CMP: begin w = {1'b0, a} - {1'b0, b}; c = w[8]; end
         OP_RLC: begin r = {a[6:0], 1'b0}; c = a[7]; end
         OP_RRC: begin r = {1'b0, a[7:1]}; c = a[0]; end
         OP_RAL: begin r = {a[6:0], c0}; c = a[7]; end
         OP_RAR: begin r = {c0, a[7:1]}; c = a[0]; end
         OP_CMA: r = ~a;
         OP_STC: c = 1'b1;
         OP_CMC: c = ~c0;
         OP_INR: r = a + 8'd1;
         OP_DCR: r = a - 8'd1;
         default: ;
      endcase
      fr = (op == OP_CMP) ? w[7:0] : r;
      return {fr[7], (fr == 8'h00), 4'b0000, c, 1'b0, r};
   endfunction

   // stand-in ALU: no reset, contents survive a sequencer reset
   logic [7:0] a_acc = 8'h00, a_tmp = 8'h00, a_flg = 8'h00, a_sav = 8'h00;
   assign alu_out   = a_acc;
   assign alu_flags = a_flg;
   always @(posedge clk) begin
      logic [15:0] rv;
      rv = alu_exec(alu_opcode, a_acc, a_tmp, a_flg);
      if (alu_tmp_write_en)   a_tmp <= alu_data;
      if (alu_acc_write_en)   a_acc <= alu_data;
      if (alu_flags_write_en) a_flg <= alu_data;
      if (alu_act_store)      a_sav <= a_acc;
      if (alu_act_restore)    a_acc <= a_sav;
      if (alu_ctrl_sig) begin a_acc <= rv[7:0]; a_flg <= rv[15:8]; end
   end

   // reference model: one expected record per busy cycle after a grant
   typedef struct {
      logic [5:0] stb;   // {tmp, ctrl, acc, flg, store, restore}
      logic       busy, done, id, err;
      logic [4:0] op;
      logic [7:0] dat, res, flg;
   } exp_t;

   exp_t q[$];
   exp_t e;
   logic [7:0] ref_acc = 8'h00, ref_flg = 8'h00, ref_sav = 8'h00;
   logic [7:0] ref_res = 8'h00, ref_rflg = 8'h00;
   logic       ref_last = 1'b1;
   logic       mw;
   logic [1:0] eg;
   bit         mon_en = 1'b0;
   bit         served[2];

   function automatic exp_t mk(input logic [5:0] stb, input logic [4:0] op, input logic [7:0] dat);
      exp_t r;
      r = '{stb: stb, busy: 1'b1, done: 1'b0, id: 1'b0, err: 1'b0, op: op, dat: dat, res: 8'h00, flg: 8'h00};
      return r;
   endfunction

   task automatic model_cmd(input logic w, input logic [2:0] k, input logic [4:0] op, input logic [7:0] d);
      logic [15:0] rv;
      logic [5:0]  xs;
      exp_t        rsp;
      rsp = mk(6'b0, 5'd0, 8'h00);
      rsp.done = 1'b1; rsp.id = w;
      if (k > 3'd5) begin
         rsp.err = 1'b1;
      end else begin
         xs = 6'b0;
         case (k)
            3'd0: begin rv = alu_exec(op, ref_acc, d, ref_flg); ref_acc = rv[7:0]; ref_flg = rv[15:8]; xs = 6'b010000; end
            3'd1: begin rv = alu_exec(op, ref_acc, 8'h00, ref_flg); ref_acc = rv[7:0]; ref_flg = rv[15:8]; xs = 6'b010000; end
            3'd2: begin ref_acc = d; xs = 6'b001000; end
            3'd3: begin ref_flg = d; xs = 6'b000100; end
            3'd4: begin ref_sav = ref_acc; xs = 6'b000010; end
            default: begin ref_acc = ref_sav; xs = 6'b000001; end
         endcase
         ref_res = ref_acc; ref_rflg = ref_flg;
         if (k == 3'd0) q.push_back(mk(6'b100000, op, d));
         q.push_back(mk(xs, op, d));
         q.push_back(mk(6'b000000, op, d));
      end
      rsp.res = ref_res; rsp.flg = ref_rflg;
      q.push_back(rsp);
   endtask

   // per-cycle comparison against the model, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         eg = 2'b00;
         if (q.size() > 0) begin
            e = q.pop_front();
         end else begin
            e = mk(6'b0, 5'd0, 8'h00);
            e.busy = 1'b0;
            if (|req) begin
               mw = (req == 2'b11) ? ~ref_last : req[1];
               eg = mw ? 2'b10 : 2'b01;
               ref_last = mw;
               served[mw] = 1'b1;
               model_cmd(mw, req_kind[3*mw +: 3], req_opcode[5*mw +: 5], req_operand[8*mw +: 8]);
            end
         end
         chk("gnt", gnt, eg);
         chk("busy", busy, e.busy);
         chk("done", done, e.done);
         chk("strobes", {alu_tmp_write_en, alu_ctrl_sig, alu_acc_write_en, alu_flags_write_en,
                         alu_act_store, alu_act_restore}, e.stb);
         chk("alu_opcode", alu_opcode, e.op);
         chk("alu_data", alu_data, e.dat);
         chk("err", err, e.err);
         chk("done_id", done_id, e.id);
         if (e.done) begin
            chk("result", result, e.res);
            chk("flags", flags, e.flg);
         end
      end
   end

   task automatic set_cmd(input int i, input logic [2:0] k, input logic [4:0] op, input logic [7:0] d);
      req_kind[3*i +: 3]    = k;
      req_opcode[5*i +: 5]  = op;
      req_operand[8*i +: 8] = d;
      req[i] = 1'b1;
   endtask

   task automatic new_cmd(input int i, input bit force_req);
      int r;
      logic [2:0] k;
      logic [4:0] op;
      r = $urandom_range(0, 13);
      k = (r < 12) ? 3'(r % 6) : 3'(6 + r - 12);
      if (k == K_BIN)      op = 5'($urandom_range(0, 7));
      else if (k == K_UNI) op = 5'($urandom_range(8, 16));
      else                 op = 5'($urandom_range(0, 31));
      set_cmd(i, k, op, 8'($urandom_range(0, 255)));
      req[i] = force_req ? 1'b1 : ($urandom_range(0, 3) != 0);
   endtask

   // issue one command, hold req until granted, return in the done cycle
   task automatic run_cmd(input int i, input logic [2:0] k, input logic [4:0] op, input logic [7:0] d);
      int n;
      set_cmd(i, k, op, d);
      for (n = 0; n < 40 && !served[i]; n++) begin @(posedge clk); #1; end
      if (!served[i]) chk("grant_timeout", 0, 1);
      served[i] = 1'b0;
      req[i] = 1'b0;
      for (n = 0; n < 40 && !done; n++) begin @(negedge clk); #1; end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic drive_cycles(input int n, input bit both);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (served[i]) begin
               served[i] = 1'b0;
               new_cmd(i, both);
            end else if (both) begin
               if (!req[i]) new_cmd(i, 1'b1);
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
               new_cmd(i, 1'b0);
            end else if (req[i] && $urandom_range(0, 31) == 0) begin
               req[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic drain();
      @(posedge clk); #1;
      req = 2'b00;
      repeat (8) @(posedge clk);
      #1;
      served[0] = 1'b0; served[1] = 1'b0;
   endtask

   logic [7:0] snap_acc, snap_flg;

   initial begin
      served[0] = 1'b0; served[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_strobes", {alu_tmp_write_en, alu_ctrl_sig, alu_acc_write_en, alu_flags_write_en,
                          alu_act_store, alu_act_restore}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // directed sequence
      run_cmd(0, K_LDA, 5'd0, 8'h3C);
      chk("lda_result", result, 8'h3C);
      chk("lda_done_id", done_id, 0);
      run_cmd(0, K_BIN, OP_ADD, 8'h05);
      chk("add_result", result, 8'h41);
      run_cmd(1, 3'd7, 5'd0, 8'hAA);
      chk("illegal_err", err, 1);
      chk("illegal_result", result, 8'h41);
      run_cmd(0, K_LDA, 5'd0, 8'h81);
      run_cmd(0, K_UNI, OP_RLC, 8'h00);
      chk("rlc_result", result, 8'h02);
      chk("rlc_carry", flags[1], 1);
      drain();

      // both requesters asserting continuously
      drive_cycles(40, 1'b1);
      drain();

      // reset in the EXEC cycle of a BIN SUB
      snap_acc = ref_acc; snap_flg = ref_flg;
      run_cmd_exec_reset();

      // randomized traffic
      drive_cycles(900, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   task automatic run_cmd_exec_reset();
      int n;
      set_cmd(0, K_BIN, OP_SUB, 8'h11);
      for (n = 0; n < 40 && !served[0]; n++) begin @(posedge clk); #1; end
      if (!served[0]) chk("grant_timeout", 0, 1);
      served[0] = 1'b0;
      req[0] = 1'b0;
      @(posedge clk); #3;            // inside EXEC
      chk("exec_ctrl", alu_ctrl_sig, 1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_ctrl_drop", alu_ctrl_sig, 0);
      chk("rst_busy_drop", busy, 0);
      q.delete();
      ref_last = 1'b1; ref_res = 8'h00; ref_rflg = 8'h00;
      ref_acc = snap_acc; ref_flg = snap_flg;
      set_cmd(0, K_LDA, 5'd0, 8'h55);
      set_cmd(1, K_LDA, 5'd0, 8'h66);
      for (n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("rst_no_done", done, 0);
      end
      @(posedge clk); #3;
      rst_n = 1'b1;
      mon_en = 1'b1;
      drive_cycles(20, 1'b0);
      drain();
   endtask

endmodule
